// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the ibex req/gnt/rvalid bus, backed by a word-addressed
// SRAM model with configurable grant/response latency and an outstanding-request cap.
module ibex_mem_responder #(
  parameter int unsigned MemSizeBytes   = 65536,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RvalidDelay    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  localparam int unsigned Words    = MemSizeBytes / 4;
  localparam int unsigned IdxW     = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned WaitW    = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam int unsigned OutW     = $clog2(MaxOutstanding + 1);
  localparam logic [31:0] AddrMask = ~32'(MemSizeBytes - 1);

  // Check bits of the inverted (39,32) SECDED code; all-zero data encodes to 7'h2A.
  function automatic logic [6:0] secded_inv_39_32_chk(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

  logic [31:0]            mem_q [Words];
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [OutW-1:0]        outstanding_q, outstanding_d;
  logic [RvalidDelay-1:0] pipe_valid_q, pipe_valid_d;
  logic [RvalidDelay-1:0] pipe_err_q, pipe_err_d;
  logic [31:0]            pipe_rdata_q [RvalidDelay];
  logic [31:0]            pipe_rdata_d [RvalidDelay];

  logic            in_range, req_err, gnt, rvalid, mem_we;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     mem_wdata;

  always_comb begin
    in_range = (addr_i & AddrMask) == BaseAddr;
    word_idx = IdxW'((addr_i >> 2) & 32'(Words - 1));
    req_err  = ~in_range | (we_i & (wdata_intg_i != secded_inv_39_32_chk(wdata_i)));

    // Gating with rst_ni keeps outputs quiet during the reset cycle itself,
    // before the synchronous clear has taken effect on the state.
    rvalid = rst_ni & pipe_valid_q[RvalidDelay-1];
    gnt    = rst_ni & req_i & (wait_cnt_q == WaitW'(GntDelay)) &
             ((outstanding_q < OutW'(MaxOutstanding)) | rvalid);

    wait_cnt_d = wait_cnt_q;
    if (!req_i || gnt)                        wait_cnt_d = '0;
    else if (wait_cnt_q != WaitW'(GntDelay))  wait_cnt_d = wait_cnt_q + WaitW'(1);

    outstanding_d = outstanding_q;
    if (gnt && !rvalid)      outstanding_d = outstanding_q + OutW'(1);
    else if (!gnt && rvalid) outstanding_d = outstanding_q - OutW'(1);

    mem_we = gnt & we_i & ~req_err;
    for (int k = 0; k < 4; k++) begin
      mem_wdata[8*k +: 8] = be_i[k] ? wdata_i[8*k +: 8] : mem_q[word_idx][8*k +: 8];
    end

    pipe_valid_d[0] = gnt;
    pipe_err_d[0]   = gnt & req_err;
    pipe_rdata_d[0] = (gnt && !we_i && !req_err) ? mem_q[word_idx] : 32'h0;
    for (int i = 1; i < RvalidDelay; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
      pipe_rdata_d[i] = pipe_rdata_q[i-1];
    end
  end

  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid;
  assign rdata_o      = rvalid ? pipe_rdata_q[RvalidDelay-1] : 32'h0;
  assign err_o        = rvalid & pipe_err_q[RvalidDelay-1];
  assign rdata_intg_o = secded_inv_39_32_chk(rdata_o);

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, which is what makes the delay line shift.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q    <= '0;
      outstanding_q <= '0;
      pipe_valid_q  <= '0;
      pipe_err_q    <= '0;
      for (int i = 0; i < RvalidDelay; i++) pipe_rdata_q[i] <= 32'h0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      outstanding_q <= outstanding_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_err_q    <= pipe_err_d;
      pipe_rdata_q  <= pipe_rdata_d;
    end
  end

  // NOTE: the memory array has no reset; contents must survive rst_ni and a reset
  // port on a RAM would prevent it from mapping onto a real SRAM macro.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[word_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder: three instances cover the default timing,
// a slow grant / long response with one outstanding, and a deep pipeline with two.
module tb_ibex_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we, gnt, rvalid, err;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be [3];
  logic [6:0]  wintg [3];
  logic [6:0]  rintg [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_mem_responder u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .wdata_intg_i(wintg[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .rdata_intg_o(rintg[0]), .err_o(err[0])
  );

  ibex_mem_responder #(.GntDelay(2), .RvalidDelay(3), .MaxOutstanding(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .wdata_intg_i(wintg[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .rdata_intg_o(rintg[1]), .err_o(err[1])
  );

  ibex_mem_responder #(.GntDelay(0), .RvalidDelay(3), .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .wdata_intg_i(wintg[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .rdata_intg_o(rintg[2]), .err_o(err[2])
  );

  // Reference (39,32) inverted SECDED check-bit encoder, used to build legal write
  // integrity and the expected read integrity.
  function automatic logic [6:0] secded_chk(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [6:0] ig);
    req[i] = r; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d; wintg[i] = ig;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 7'h0);
  endtask

  // One isolated transaction on instance A: same-cycle grant, response one cycle later.
  task automatic a_op(input string tag, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic [6:0] ig,
                      input logic [31:0] exp_rd, input logic exp_err);
    next_cycle();
    drive(0, 1'b1, w, a, b, d, ig);
    mid();
    check({tag, ".gnt"}, 32'(gnt[0]), 32'd1);
    check({tag, ".rvalid_early"}, 32'(rvalid[0]), 32'd0);
    next_cycle();
    idle(0);
    mid();
    check({tag, ".rvalid"}, 32'(rvalid[0]), 32'd1);
    check({tag, ".rdata"}, rdata[0], exp_rd);
    check({tag, ".err"}, 32'(err[0]), 32'(exp_err));
    check({tag, ".rintg"}, 32'(rintg[0]), 32'(secded_chk(exp_rd)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] b_gnt, b_rv;
    logic [8:0]  c_gnt, c_rv;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) idle(i);

    // Request held during reset must not be granted; outputs sit at their idle values.
    drive(0, 1'b1, 1'b0, 32'h0010_0010, 4'hF, 32'h0, 7'h0);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      mid();
      check("rst.gnt", 32'(gnt[0]), 32'd0);
      check("rst.rvalid", 32'(rvalid[0]), 32'd0);
      check("rst.rdata", rdata[0], 32'h0);
      check("rst.err", 32'(err[0]), 32'd0);
      check("rst.rintg", 32'(rintg[0]), 32'h2A);
    end
    next_cycle();
    idle(0);
    rst_n = 1'b1;

    // Instance A: full write, read, partial write, error cases and address boundaries.
    a_op("a_wr_full", 1'b1, 32'h0010_0010, 4'hF, 32'hDEADBEEF, secded_chk(32'hDEADBEEF), 32'h0, 1'b0);
    a_op("a_rd_full", 1'b0, 32'h0010_0010, 4'hF, 32'h0, 7'h0, 32'hDEADBEEF, 1'b0);
    a_op("a_wr_part", 1'b1, 32'h0010_0010, 4'b0101, 32'h11223344, secded_chk(32'h11223344), 32'h0, 1'b0);
    a_op("a_rd_part", 1'b0, 32'h0010_0010, 4'hF, 32'h0, 7'h0, 32'hDE22BE44, 1'b0);
    a_op("a_rd_low", 1'b0, 32'h0000_0000, 4'hF, 32'h0, 7'h0, 32'h0, 1'b1);
    a_op("a_wr_badintg", 1'b1, 32'h0010_0010, 4'hF, 32'h55555555,
         secded_chk(32'h55555555) ^ 7'h01, 32'h0, 1'b1);
    a_op("a_rd_unchanged", 1'b0, 32'h0010_0010, 4'hF, 32'h0, 7'h0, 32'hDE22BE44, 1'b0);
    a_op("a_wr_last", 1'b1, 32'h0010_FFFC, 4'hF, 32'hCAFEF00D, secded_chk(32'hCAFEF00D), 32'h0, 1'b0);
    a_op("a_rd_high", 1'b0, 32'h0011_0000, 4'hF, 32'h0, 7'h0, 32'h0, 1'b1);
    a_op("a_rd_last", 1'b0, 32'h0010_FFFF, 4'hF, 32'h0, 7'h0, 32'hCAFEF00D, 1'b0);

    // Back-to-back write then read: the earlier-granted write is visible to the read.
    next_cycle();
    drive(0, 1'b1, 1'b1, 32'h0010_0020, 4'hF, 32'h12345678, secded_chk(32'h12345678));
    mid();
    check("a_b2b.gnt0", 32'(gnt[0]), 32'd1);
    next_cycle();
    drive(0, 1'b1, 1'b0, 32'h0010_0020, 4'hF, 32'h0, 7'h0);
    mid();
    check("a_b2b.gnt1", 32'(gnt[0]), 32'd1);
    check("a_b2b.rvalid0", 32'(rvalid[0]), 32'd1);
    check("a_b2b.rdata0", rdata[0], 32'h0);
    next_cycle();
    idle(0);
    mid();
    check("a_b2b.rvalid1", 32'(rvalid[0]), 32'd1);
    check("a_b2b.rdata1", rdata[0], 32'h12345678);

    // Instance B: grant on 3rd request cycle, next grant only when the predecessor retires.
    b_gnt = 12'b0001_0010_0100;
    b_rv  = 12'b1001_0010_0000;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if (c < 9) drive(1, 1'b1, 1'b1, 32'h0010_0100, 4'hF, 32'hA5A5A5A5, secded_chk(32'hA5A5A5A5));
      else       idle(1);
      mid();
      check($sformatf("b_gnt[%0d]", c), 32'(gnt[1]), 32'(b_gnt[c]));
      check($sformatf("b_rvalid[%0d]", c), 32'(rvalid[1]), 32'(b_rv[c]));
      check($sformatf("b_err[%0d]", c), 32'(err[1]), 32'd0);
    end

    // Instance C: two outstanding; a grant at the limit needs a same-cycle retire.
    c_gnt = 9'b0_0001_1011;
    c_rv  = 9'b0_1101_1000;
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      if (c < 6) drive(2, 1'b1, 1'b1, 32'h0010_0040, 4'hF, 32'h0BADCAFE, secded_chk(32'h0BADCAFE));
      else       idle(2);
      mid();
      check($sformatf("c_gnt[%0d]", c), 32'(gnt[2]), 32'(c_gnt[c]));
      check($sformatf("c_rvalid[%0d]", c), 32'(rvalid[2]), 32'(c_rv[c]));
    end

    // Reset with two reads in flight: no late responses, next request served normally.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      drive(2, 1'b1, 1'b0, 32'h0010_0040, 4'hF, 32'h0, 7'h0);
      mid();
      check($sformatf("c_rst.gnt%0d", c), 32'(gnt[2]), 32'd1);
    end
    next_cycle();
    idle(2);
    rst_n = 1'b0;
    mid();
    check("c_rst.rvalid_in_rst0", 32'(rvalid[2]), 32'd0);
    next_cycle();
    mid();
    check("c_rst.rvalid_in_rst1", 32'(rvalid[2]), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    mid();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("c_rst.no_late_rvalid[%0d]", c), 32'(rvalid[2]), 32'd0);
      next_cycle();
      mid();
    end
    next_cycle();
    drive(2, 1'b1, 1'b0, 32'h0010_0040, 4'hF, 32'h0, 7'h0);
    mid();
    check("c_post.gnt", 32'(gnt[2]), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      idle(2);
      mid();
      check($sformatf("c_post.rvalid[%0d]", c), 32'(rvalid[2]), 32'(c == 3));
    end
    check("c_post.rdata", rdata[2], 32'h0BADCAFE);
    check("c_post.rintg", 32'(rintg[2]), 32'(secded_chk(32'h0BADCAFE)));

    // Memory written before the reset is retained.
    a_op("a_retained", 1'b0, 32'h0010_0010, 4'hF, 32'h0, 7'h0, 32'hDE22BE44, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_mem_responder.md
Name: ibex_mem_responder

Overview:
- Bus responder for the ibex instruction/data memory interface. Implements the memory side of the req/gnt/rvalid protocol that the core initiates.
- Backed by an internal word-addressed SRAM model, with configurable grant and response latency and a bounded number of outstanding requests.
- Generates read-data integrity and checks write-data integrity.
- Instantiated in simulation tops next to ibex_top, one instance per bus, or one shared instance for a unified memory.

Parameters:
- MemSizeBytes, 65536: memory size in bytes; power of two, ≥4.
- BaseAddr, 32'h0010_0000: byte address of word 0; aligned to MemSizeBytes.
- GntDelay, 0: cycles req_i must be held high before gnt_o asserts; 0 allows a same-cycle grant.
- RvalidDelay, 1: cycles from the grant cycle to the rvalid_o cycle; ≥1.
- MaxOutstanding, 2: maximum granted requests not yet answered; ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  request valid
- gnt_o  out  1  request granted (combinational from req_i and state)
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- wdata_intg_i  in  7  write-data integrity bits
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- rdata_intg_o  out  7  read-data integrity bits
- err_o  out  1  response error, valid with rvalid_o

Behaviour:
- Reset: one clock, clk_i; reset is synchronous, active-low, on rst_ni.
  - While rst_ni=0: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, rdata_intg_o=7'h2A (encoding of 0).
  - Pending responses are discarded, the outstanding count and wait counter clear, memory contents are retained.
  - A reset mid-transaction produces no late rvalid_o.
- Grant rule: gnt_o = req_i & (wait_cnt == GntDelay) & (outstanding < MaxOutstanding, or a response retires this cycle).
- wait_cnt:
  - Increments (saturating at GntDelay) each cycle req_i=1 and gnt_o=0.
  - Clears on a grant or when req_i=0.
- Acceptance: a handshake occurs when req_i & gnt_o. All request fields are sampled in that cycle.
- Error classification, at acceptance:
  - err = address outside [BaseAddr, BaseAddr+MemSizeBytes), OR (we_i & wdata_intg_i ≠ prim_secded_inv_39_32_enc(wdata_i) check bits).
- Writes: when not err, each byte lane with be_i[k]=1 is written at the clock edge ending the grant cycle. The response carries rdata=0.
- Reads: when not err, data is the full word from the memory array as it was at the grant cycle. A write granted earlier is visible; a write granted the same cycle does not apply.
- Errored request: no memory update, response rdata=0, err=1.
- Response pipeline:
  - Each accepted request enters an in-order delay line of depth RvalidDelay.
  - rvalid_o=1 exactly RvalidDelay cycles after the grant cycle, for one cycle, carrying that request's rdata/err.
  - rdata_o/err_o = 0 when rvalid_o=0.
  - rdata_intg_o = prim_secded_inv_39_32_enc(rdata_o) check bits, always.
- Outstanding counter:
  - +1 on grant, −1 on rvalid_o; both in the same cycle gives a net 0.
  - Never exceeds MaxOutstanding. The same-cycle retire permits a grant at the limit.
- Back-to-back: with GntDelay=0, a new grant is possible every cycle, subject to the outstanding limit. Responses stay in grant order.
- req_i dropping before a grant is legal: no state change other than clearing wait_cnt.

Test Plan:
- Reset, then read of a location → rvalid_o=0 and rdata_intg_o=7'h2A during reset; memory pre-written before reset still reads back after rst_ni=1.
- GntDelay=0, RvalidDelay=1: write 32'hDEADBEEF be=4'hF at 0x0010_0010, then read → gnt same cycle as req; rvalid one cycle after each grant; read returns 32'hDEADBEEF, err_o=0.
- Partial write be=4'b0101 data 32'h11223344 over 32'hDEADBEEF → subsequent read returns 32'hDE22BE44.
- GntDelay=2, RvalidDelay=3, MaxOutstanding=1: req held continuously → gnt on the 3rd cycle of req; next gnt is not issued before the cycle its predecessor's rvalid_o asserts; outstanding never exceeds 1.
- Read at 0x0000_0000 and write with wdata_intg_i bit 0 flipped → both give err_o=1, rdata_o=0; the target word is unchanged on re-read.
- Reset asserted with 2 outstanding reads → no rvalid_o after reset deasserts; the first post-reset request is granted normally.
